// File: rtl/ipg_tx_sched.sv
// ipg_tx_sched: arbitrates chunk sources onto PHY gap slots, locking the grant for a whole message.
// Optional IPG_SCHED_STRICT_PRIO_EN: requester 0 always wins arbitration when valid.
module ipg_tx_sched #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 6,
  parameter int TIMEOUT    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            slot_avail,
  input  logic [LEN_WIDTH-1:0]            slot_len,
  output logic                            tx_valid,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic [LEN_WIDTH-1:0]            tx_len,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            err_timeout,
  output logic [15:0]                     chunk_count
);
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int SLOTS = 1 << PTR_W;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                state_reg, state_next;
  logic [NUM_REQ-1:0]    grant_reg, grant_next;
  logic [PTR_W-1:0]      owner_reg, owner_next;
  logic [PTR_W-1:0]      rr_reg, rr_next;
  logic [7:0]            idle_reg, idle_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic [DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
  logic [LEN_WIDTH-1:0]  tx_len_reg, tx_len_next;
  logic                  err_reg, err_next;
  logic [15:0]           count_reg, count_next;

  // Per-requester views padded to a power of two so the owner index never leaves the array.
  logic [DATA_WIDTH-1:0] data_arr  [SLOTS];
  logic [LEN_WIDTH-1:0]  len_arr   [SLOTS];
  logic [SLOTS-1:0]      valid_ext;
  logic [SLOTS-1:0]      last_ext;
  logic [NUM_REQ-1:0]    cand;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  fit;
  logic                  xfer;
  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  int                    idx;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_real
        assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign len_arr[gi]   = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
        assign valid_ext[gi] = req_valid[gi];
        assign last_ext[gi]  = req_last[gi];
      end else begin : g_pad
        assign data_arr[gi]  = '0;
        assign len_arr[gi]   = '0;
        assign valid_ext[gi] = 1'b0;
        assign last_ext[gi]  = 1'b0;
      end
    end
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_reg[gi] & fit;
    end
  endgenerate

  assign sel_len = len_arr[owner_reg];
  assign fit     = slot_avail && (sel_len <= slot_len);
  assign xfer    = (state_reg == LOCK) && valid_ext[owner_reg] && fit;

`ifdef IPG_SCHED_STRICT_PRIO_EN
  assign cand = {req_valid[NUM_REQ-1:1], 1'b0};
`else
  assign cand = req_valid;
`endif

  function automatic logic [PTR_W-1:0] rr_after(input logic [PTR_W-1:0] g);
    int n;
    n = (int'(g) + 1) % NUM_REQ;
`ifdef IPG_SCHED_STRICT_PRIO_EN
    if (n == 0) n = 1;
`endif
    return PTR_W'(n);
  endfunction

  // Scan downward so the candidate closest to rr_reg is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_reg) + k) % NUM_REQ;
      if (cand[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
`ifdef IPG_SCHED_STRICT_PRIO_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    rr_next       = rr_reg;
    idle_next     = idle_reg;
    tx_valid_next = 1'b0;
    tx_data_next  = tx_data_reg;
    tx_len_next   = tx_len_reg;
    err_next      = 1'b0;
    count_next    = count_reg;
    case (state_reg)
      IDLE: begin
        idle_next = '0;
        if (win_found) begin
          state_next = LOCK;
          owner_next = win_idx;
          grant_next = NUM_REQ'(1) << win_idx;
        end
      end
      LOCK: begin
        if (xfer) begin
          idle_next = '0;
          if (sel_len != '0) begin
            tx_valid_next = 1'b1;
            tx_data_next  = data_arr[owner_reg];
            tx_len_next   = sel_len;
            count_next    = count_reg + 16'd1;
          end
          if (last_ext[owner_reg]) begin
            state_next = IDLE;
            grant_next = '0;
            rr_next    = rr_after(owner_reg);
          end
        end else if (idle_reg == 8'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
          grant_next = '0;
          rr_next    = rr_after(owner_reg);
          idle_next  = '0;
        end else begin
          idle_next = idle_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      rr_reg       <= '0;
      idle_reg     <= '0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_len_reg   <= '0;
      err_reg      <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      rr_reg       <= rr_next;
      idle_reg     <= idle_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      tx_len_reg   <= tx_len_next;
      err_reg      <= err_next;
      count_reg    <= count_next;
    end
  end

  assign grant       = grant_reg;
  assign tx_valid    = tx_valid_reg;
  assign tx_data     = tx_data_reg;
  assign tx_len      = tx_len_reg;
  assign err_timeout = err_reg;
  assign chunk_count = count_reg;
endmodule
